// File: rtl/gpr_wb_arbiter_pkg.sv
// rtl/gpr_wb_arbiter_pkg.sv - shared write-back constants, flag-op encodings and request record
package gpr_wb_arbiter_pkg;

    localparam int         WB_NREQ       = 3;
    localparam logic [4:0] REG_ADDR_FLAG = 5'd31;

    typedef enum logic [1:0] {
        FLAG_OP_DIS        = 2'b00,
        FLAG_OP_SET        = 2'b01,
        FLAG_OP_SET_AND_WR = 2'b10
    } flag_op_e;

    typedef struct packed {
        logic        we;
        logic        flag;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] nflag;
    } wb_req_t;

    function automatic flag_op_e flag_op_of(input logic we, input logic flag);
        if (we && flag) return FLAG_OP_SET_AND_WR;
        if (flag)       return FLAG_OP_SET;
        return FLAG_OP_DIS;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write bits and decode read-hazard stall
module wb_scoreboard
    import gpr_wb_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_addr,
    input  logic        rsv_flag,
    input  logic        wr_en,
    input  logic        flag_wr,
    input  logic [4:0]  wr_addr,
    input  logic [4:0]  rd_a1,
    input  logic [4:0]  rd_a2,
    output logic        stall,
    output logic [31:0] busy
);

    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (rsv_valid) set_mask[rsv_addr]      = 1'b1;
        if (rsv_flag)  set_mask[REG_ADDR_FLAG] = 1'b1;
        set_mask[0] = 1'b0;
        if (wr_en)     clr_mask[wr_addr]       = 1'b1;
        if (flag_wr)   clr_mask[REG_ADDR_FLAG] = 1'b1;
    end

    // Clear is applied first so a reservation on the commit edge survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) busy <= '0;
        else       busy <= (busy & ~clr_mask) | set_mask;
    end

    assign stall = ((rd_a1 != 5'd0) && busy[rd_a1]) || ((rd_a2 != 5'd0) && busy[rd_a2]);

endmodule

// File: rtl/gpr_wb_arbiter.sv
// rtl/gpr_wb_arbiter.sv - GPR write-back arbiter with registered register-file drive stage
// Optional round-robin arbitration when WB_RR_ARB_EN is defined; fixed priority otherwise.
module gpr_wb_arbiter
    import gpr_wb_arbiter_pkg::*;
#(
    parameter int NREQ = WB_NREQ
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ-1:0]   req_flag,
    input  logic [5*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_data,
    input  logic [32*NREQ-1:0] req_nflag,
    input  logic              rsv_valid,
    input  logic [4:0]        rsv_addr,
    input  logic              rsv_flag,
    input  logic [4:0]        rd_a1,
    input  logic [4:0]        rd_a2,
    output logic              stall,
    output logic [31:0]       busy,
    output logic              WE,
    output logic [1:0]        FlagOp,
    output logic [4:0]        AWr,
    output logic [31:0]       Din,
    output logic [31:0]       NFlag
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            grant_any;
    int              idx;
    wb_req_t         sel;
    flag_op_e        fop_q;

`ifdef WB_RR_ARB_EN
    logic [PW-1:0] ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)          ptr <= '0;
        else if (grant_any) ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PW'(1);
    end
`endif

    // Single search loop; only the starting index differs between the two schemes.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
`ifdef WB_RR_ARB_EN
            idx = (int'(ptr) + k) % NREQ;
`else
            idx = k;
`endif
            if (!grant_any && !reset && req_valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                grant_any  = 1'b1;
            end
        end
    end

    assign req_ready = grant;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel.we    = req_we[i];
                sel.flag  = req_flag[i];
                sel.addr  = req_addr[5*i +: 5];
                sel.data  = req_data[32*i +: 32];
                sel.nflag = req_nflag[32*i +: 32];
            end
        end
    end

    // Idle cycles drop the strobes but keep the last payload on AWr/Din/NFlag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            WE    <= 1'b0;
            fop_q <= FLAG_OP_DIS;
            AWr   <= '0;
            Din   <= '0;
            NFlag <= '0;
        end else if (grant_any) begin
            WE    <= sel.we;
            fop_q <= flag_op_of(sel.we, sel.flag);
            AWr   <= sel.addr;
            Din   <= sel.data;
            NFlag <= sel.nflag;
        end else begin
            WE    <= 1'b0;
            fop_q <= FLAG_OP_DIS;
        end
    end

    assign FlagOp = fop_q;

    wb_scoreboard u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_flag  (rsv_flag),
        .wr_en     (WE),
        .flag_wr   (fop_q != FLAG_OP_DIS),
        .wr_addr   (AWr),
        .rd_a1     (rd_a1),
        .rd_a2     (rd_a2),
        .stall     (stall),
        .busy      (busy)
    );

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// tb/tb_gpr_wb_arbiter.sv - randomized and directed bench for gpr_wb_arbiter against a behavioural model
module tb_gpr_wb_arbiter;
    import gpr_wb_arbiter_pkg::*;

    localparam int N = WB_NREQ;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_we, req_flag;
    logic [5*N-1:0]    req_addr;
    logic [32*N-1:0]   req_data, req_nflag;
    logic              rsv_valid, rsv_flag;
    logic [4:0]        rsv_addr, rd_a1, rd_a2;
    logic              stall;
    logic [31:0]       busy;
    logic              WE;
    logic [1:0]        FlagOp;
    logic [4:0]        AWr;
    logic [31:0]       Din, NFlag;

    gpr_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_flag(req_flag),
        .req_addr(req_addr), .req_data(req_data), .req_nflag(req_nflag),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_flag(rsv_flag),
        .rd_a1(rd_a1), .rd_a2(rd_a2), .stall(stall), .busy(busy),
        .WE(WE), .FlagOp(FlagOp), .AWr(AWr), .Din(Din), .NFlag(NFlag)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Requester-side view: each producer holds its write-back until granted.
    logic        r_valid[N];
    logic        r_we[N];
    logic        r_flag[N];
    logic [4:0]  r_addr[N];
    logic [31:0] r_data[N];
    logic [31:0] r_nflag[N];

    // Model of what the register file sees and which registers are still owed a write.
    bit          m_busy[32];
    logic        m_we;
    logic [1:0]  m_fop;
    logic [4:0]  m_awr;
    logic [31:0] m_din, m_nflag;
`ifdef WB_RR_ARB_EN
    int          m_ptr;
`endif

    int          obs_grant;
    logic        obs_stall;
    logic [N-1:0] obs_ready;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int model_grant();
        int i;
        for (int k = 0; k < N; k++) begin
`ifdef WB_RR_ARB_EN
            i = (m_ptr + k) % N;
`else
            i = k;
`endif
            if (r_valid[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_we = 1'b0; m_fop = FLAG_OP_DIS; m_awr = '0; m_din = '0; m_nflag = '0;
`ifdef WB_RR_ARB_EN
        m_ptr = 0;
`endif
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = r_valid[i];
            req_we[i]            = r_we[i];
            req_flag[i]          = r_flag[i];
            req_addr[5*i +: 5]   = r_addr[i];
            req_data[32*i +: 32] = r_data[i];
            req_nflag[32*i +: 32] = r_nflag[i];
        end
    endtask

    task automatic post(input int i, input logic we, input logic flag, input logic [4:0] addr,
                        input logic [31:0] data, input logic [31:0] nflag);
        r_valid[i] = 1'b1; r_we[i] = we; r_flag[i] = flag;
        r_addr[i] = addr; r_data[i] = data; r_nflag[i] = nflag;
    endtask

    task automatic step();
        int g;
        drive();
        #1;
        g = model_grant();
        obs_ready = req_ready;
        obs_stall = stall;
        obs_grant = -1;
        for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
        check("ready", req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
        check("stall", stall, ((rd_a1 != 0 && m_busy[rd_a1]) || (rd_a2 != 0 && m_busy[rd_a2])) ? 32'd1 : 32'd0);
        // Commit the write presented this cycle, then apply this cycle's reservations.
        if (m_we) m_busy[m_awr] = 1'b0;
        if (m_fop != FLAG_OP_DIS) m_busy[REG_ADDR_FLAG] = 1'b0;
        if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
        if (rsv_flag) m_busy[REG_ADDR_FLAG] = 1'b1;
        if (g >= 0) begin
            m_we    = r_we[g];
            m_fop   = (r_we[g] && r_flag[g]) ? FLAG_OP_SET_AND_WR : r_flag[g] ? FLAG_OP_SET : FLAG_OP_DIS;
            m_awr   = r_addr[g];
            m_din   = r_data[g];
            m_nflag = r_nflag[g];
            r_valid[g] = 1'b0;
`ifdef WB_RR_ARB_EN
            m_ptr = (g + 1) % N;
`endif
        end else begin
            m_we  = 1'b0;
            m_fop = FLAG_OP_DIS;
        end
        @(posedge clk);
        #1;
        check("we", WE, m_we);
        check("flagop", FlagOp, m_fop);
        check("busy", busy, model_busy());
        if (m_we) begin
            check("awr", AWr, m_awr);
            check("din", Din, m_din);
        end
        if (m_fop != FLAG_OP_DIS) check("nflag", NFlag, m_nflag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        drive();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_we", WE, 0);
        check("rst_flagop", FlagOp, FLAG_OP_DIS);
        check("rst_awr", AWr, 0);
        check("rst_din", Din, 0);
        check("rst_nflag", NFlag, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < N; i++) post(i, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        for (int i = 0; i < N; i++) r_valid[i] = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        rsv_valid = 1'b0; rsv_addr = '0; rsv_flag = 1'b0; rd_a1 = '0; rd_a2 = '0;
        clear_reqs();
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        post(1, 1'b1, 1'b0, 5'd9, 32'h1234, 32'h0);
        do_reset();
        clear_reqs();

        // Single write from requester 1, then an idle cycle that must hold the payload.
        post(1, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0);
        step();
        check("single_ready", obs_ready, 3'b010);
        check("single_we", WE, 1);
        check("single_awr", AWr, 5);
        check("single_din", Din, 32'hDEADBEEF);
        check("single_flagop", FlagOp, FLAG_OP_DIS);
        step();
        check("idle_we", WE, 0);
        check("idle_awr_hold", AWr, 5);
        check("idle_din_hold", Din, 32'hDEADBEEF);

        post(0, 1'b1, 1'b1, 5'd3, 32'h55, 32'h1);
        step();
        check("wrflag_op", FlagOp, FLAG_OP_SET_AND_WR);
        check("wrflag_nflag", NFlag, 1);
        post(2, 1'b0, 1'b1, 5'd4, 32'h0, 32'hA5A5);
        step();
        check("flag_op", FlagOp, FLAG_OP_SET);
        check("flag_we", WE, 0);
        post(2, 1'b0, 1'b0, 5'd6, 32'h77, 32'h0);
        step();
        check("nop_we", WE, 0);
        check("nop_flagop", FlagOp, FLAG_OP_DIS);

        // Write accepted, then reset before the commit edge drops it.
        post(0, 1'b1, 1'b0, 5'd8, 32'hCAFE, 32'h0);
        step();
        do_reset();

        // Three-way contention with every requester re-armed each cycle.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++)
                if (!r_valid[i]) post(i, 1'b1, 1'b0, 5'(10 + i), 32'(c * 16 + i), 32'h0);
            step();
`ifdef WB_RR_ARB_EN
            check("contend_grant", obs_grant, c);
`else
            check("contend_grant", obs_grant, 0);
`endif
        end
        clear_reqs();
        step();
        step();

        // Scoreboard: reserve r7, write r7, watch stall fall one edge after acceptance.
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        rsv_valid = 1'b0; rd_a1 = 5'd7;
        step();
        check("sb_stall_set", obs_stall, 1);
        post(1, 1'b1, 1'b0, 5'd7, 32'h7777, 32'h0);
        step();
        check("sb_stall_accept", obs_stall, 1);
        step();
        check("sb_stall_hold", obs_stall, 1);
        step();
        check("sb_stall_clear", obs_stall, 0);

        rd_a1 = 5'd0; rsv_valid = 1'b1; rsv_addr = 5'd0;
        step();
        rsv_valid = 1'b0;
        step();
        check("sb_zero_stall", obs_stall, 0);
        check("sb_zero_busy", busy[0], 0);

        // Re-reserve r7 on the commit edge of an r7 write.
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        rsv_valid = 1'b0;
        post(0, 1'b1, 1'b0, 5'd7, 32'h1, 32'h0);
        step();
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        step();
        rsv_valid = 1'b0;
        check("collision_busy7", busy[7], 1);

        rsv_flag = 1'b1;
        step();
        rsv_flag = 1'b0;
        check("flag_busy", busy[REG_ADDR_FLAG], 1);

        // Randomized traffic against the model, with one mid-run reset.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < N; i++)
                if (!r_valid[i] && $urandom_range(0, 2) != 0)
                    post(i, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom);
            rsv_valid = ($urandom_range(0, 3) == 0);
            rsv_addr  = 5'($urandom_range(0, 9));
            rsv_flag  = ($urandom_range(0, 6) == 0);
            rd_a1     = 5'($urandom_range(0, 9));
            rd_a2     = ($urandom_range(0, 1) == 0) ? REG_ADDR_FLAG : 5'($urandom_range(0, 9));
            step();
            if (t == 300) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
